lcd_hd44780_refresh: RTL and testbench
======================================

// Module: lcd_hd44780_refresh
// PURPOSE
//  Consumes the 32-char stream from the binary-to-LCD formatter via write port (dat/addr/we) into a
//  32x8 character buffer. Initialises an HD44780 16x2 LCD over an 8-bit bus, then refreshes it continuously.
//  Buffer chars 0-15 go to line 1 (DDRAM 0x00), chars 16-31 to line 2 (DDRAM 0x40).
//  frame_done may trigger the formatter's next update.
// PARAMETERS
//  T_POWERUP  750000  cycles after reset before first command (15 ms @ 50 MHz)
//  T_AS       2       cycles RS/DB stable before E rises
//  T_PW       25      cycles E high
//  T_CMD      2500    cycles after E falls before next transaction (normal cmd/char)
//  T_CLEAR    100000  cycles after E falls following clear (0x01)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  wr_data     in   8  character byte from formatter
//  wr_addr     in   5  buffer position 0..31
//  wr_en       in   1  write strobe, one byte per cycle
//  lcd_rs      out  1  0 = command, 1 = data
//  lcd_rw      out  1  always 0 (write only)
//  lcd_e       out  1  enable strobe
//  lcd_db      out  8  data bus
//  init_done   out  1  high once init sequence complete, stays high until reset
//  frame_done  out  1  one-cycle pulse at end of each full 2-line refresh
// BEHAVIOUR
//  Reset (rst=1 at clk edge) sets:
//   - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, init_done=0, frame_done=0.
//   - All 32 buffer bytes to 0x20 (space); state to PWRUP_WAIT.
//   - Applies mid-transaction too: E drops on that edge, full re-init follows.
//  Buffer writes: wr_en=1 writes wr_data to wr_addr on the edge. Accepted in every state, never stalls, no backpressure.
//  Transaction (every cmd/char), sub-phases:
//   - SETUP (T_AS cycles, E=0): RS/DB driven. Char byte latched from buffer on SETUP entry.
//   - EHIGH (T_PW cycles, E=1).
//   - WAIT (T_CMD or T_CLEAR cycles, E=0).
//   - RS/DB held constant through all three phases. Total = T_AS+T_PW+T_wait cycles.
//  FSM:
//   - PWRUP_WAIT: count T_POWERUP cycles, bus idle -> INIT, index 0.
//   - INIT: command ROM, issued in order, RS=0: 0x38,0x38,0x38,0x38,0x08,0x01,0x06,0x0C.
//     - Wait after 0x01 is T_CLEAR, all others T_CMD.
//     - After WAIT of 0x0C: init_done<=1 -> LINE1_ADDR.
//   - LINE1_ADDR: cmd 0x80 -> CHARS, idx 0..15 (RS=1, DB=buf[idx]).
//   - After idx 15 -> LINE2_ADDR: cmd 0xC0 -> CHARS idx 16..31.
//   - After WAIT of idx 31: frame_done=1 for exactly one cycle -> LINE1_ADDR (no idle gap).
//  Frame = 34 transactions = 34*(T_AS+T_PW+T_CMD) cycles, constant.
//  Write/read collision:
//   - Write to the address being latched on SETUP entry: old byte displayed this frame, new byte next frame.
//   - Writes to other addresses during a frame show on that frame if their position is not yet latched.
//  Counters sized to hold the largest parameter. No BUSY-flag reads; timing is purely count-based.
// TESTING  (bench params: T_POWERUP=100, T_AS=2, T_PW=4, T_CMD=10, T_CLEAR=40)
//  1 Init timing: release rst.
//    - lcd_e=0 for 100 cycles.
//    - Then 8 E pulses, each high exactly 4 cycles, RS=0, DB = 38,38,38,38,08,01,06,0C.
//    - Fall of 0x01 pulse to next SETUP = 40 cycles; init_done rises after 0x0C wait.
//  2 Default content, no writes:
//    - Pulse 0x80 (RS=0), 16 pulses RS=1 DB=0x20.
//    - Then 0xC0 (RS=0), 16 pulses 0x20.
//    - frame_done 1-cycle pulse; period 544 cycles.
//  3 Write during init: wr 0x58@0, 0x3A@1, 0x31@16.
//    - Line 1 chars 58,3A then 14x20.
//    - Line 2 first char 31.
//  4 Collision: wr 0x41@5 on the exact SETUP-entry cycle of idx 5.
//    - DB=old value (0x20) this frame, 0x41 next frame.
//  5 Mid-op reset: rst=1 during EHIGH of a char.
//    - lcd_e=0, init_done=0 next edge.
//    - 100-cycle power-up wait, full init repeats, line 1 shows all 0x20.
//  6 Continuous writes every cycle (wr_en=1, random addr/data) for 3 frames:
//    - No E glitches, pulse widths unchanged.
//    - Final frame DB values match bench buffer model.

Source files
------------

// File: rtl/lcd_hd44780_refresh.sv
// Continuous HD44780 16x2 refresh engine with a 32-byte character buffer.
// After power-up it runs the fixed init command sequence. It then streams the
// buffer to the LCD forever, one frame at a time:
//   0x80, buf[0..15], 0xC0, buf[16..31]
// Each command or character goes out as one bus transaction with three phases:
// SETUP (E low), EHIGH (E high) and WAIT (E low). RS and DB are held for the
// whole transaction.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wr_data/addr/en   buffer write port, one byte per cycle, never stalls
//   lcd_rs/rw/e/db    HD44780 8-bit write-only bus
//   init_done         high once the init sequence has finished
//   frame_done        one-cycle pulse after each complete 2-line refresh
module lcd_hd44780_refresh #(
   parameter int unsigned T_POWERUP = 750000,
   parameter int unsigned T_AS      = 2,
   parameter int unsigned T_PW      = 25,
   parameter int unsigned T_CMD     = 2500,
   parameter int unsigned T_CLEAR   = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] wr_data,
   input  logic [4:0] wr_addr,
   input  logic       wr_en,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_db,
   output logic       init_done,
   output logic       frame_done
);

   localparam int unsigned MaxA = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
   localparam int unsigned MaxB = (T_CMD > T_PW) ? T_CMD : T_PW;
   localparam int unsigned MaxC = (MaxB > T_AS) ? MaxB : T_AS;
   localparam int unsigned MaxT = (MaxA > MaxC) ? MaxA : MaxC;
   localparam int unsigned CntW = $clog2(MaxT + 1);

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t PwrLast = cnt_t'(T_POWERUP - 1);
   localparam cnt_t AsLast  = cnt_t'(T_AS - 1);
   localparam cnt_t PwLast  = cnt_t'(T_PW - 1);
   localparam cnt_t CmdLast = cnt_t'(T_CMD - 1);
   localparam cnt_t ClrLast = cnt_t'(T_CLEAR - 1);

   typedef enum logic [2:0] {StPwrupWait, StInit, StLine1Addr, StChars, StLine2Addr} state_e;
   typedef enum logic [1:0] {PhSetup, PhEhigh, PhWait} phase_e;

   state_e     state_q, state_d;
   phase_e     phase_q, phase_d;
   cnt_t       cnt_q, cnt_d, wait_last;
   logic [4:0] idx_q, idx_d;
   logic       rs_q, rs_d;
   logic [7:0] db_q, db_d;
   logic       init_done_q, init_done_d;
   logic       frame_done_q, frame_done_d;
   logic       start;
   logic [7:0] char_q [32];

   function automatic logic [7:0] init_cmd(input logic [2:0] i);
      case (i)
         3'd0, 3'd1, 3'd2, 3'd3: init_cmd = 8'h38;
         3'd4:                   init_cmd = 8'h08;
         3'd5:                   init_cmd = 8'h01;
         3'd6:                   init_cmd = 8'h06;
         default:                init_cmd = 8'h0C;
      endcase
   endfunction

   // Writes are accepted in every state. A write landing on the same edge that
   // latches that position is seen only on the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) char_q[i] <= 8'h20;
      end else if (wr_en) begin
         char_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StPwrupWait;
         phase_q      <= PhSetup;
         cnt_q        <= '0;
         idx_q        <= '0;
         rs_q         <= 1'b0;
         db_q         <= 8'h00;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         rs_q         <= rs_d;
         db_q         <= db_d;
         init_done_q  <= init_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      cnt_d        = cnt_q + 1'b1;
      idx_d        = idx_q;
      rs_d         = rs_q;
      db_d         = db_q;
      init_done_d  = init_done_q;
      frame_done_d = 1'b0;
      start        = 1'b0;
      // The clear command needs the long settle time.
      wait_last    = (state_q == StInit && idx_q == 5'd5) ? ClrLast : CmdLast;

      if (state_q == StPwrupWait) begin
         if (cnt_q == PwrLast) begin
            state_d = StInit;
            idx_d   = '0;
            start   = 1'b1;
         end
      end else begin
         unique case (phase_q)
            PhSetup: if (cnt_q == AsLast) begin
               phase_d = PhEhigh;
               cnt_d   = '0;
            end
            PhEhigh: if (cnt_q == PwLast) begin
               phase_d = PhWait;
               cnt_d   = '0;
            end
            PhWait: if (cnt_q == wait_last) begin
               start = 1'b1;
               case (state_q)
                  StInit: begin
                     if (idx_q == 5'd7) begin
                        init_done_d = 1'b1;
                        state_d     = StLine1Addr;
                     end else begin
                        idx_d = idx_q + 5'd1;
                     end
                  end
                  StLine1Addr: begin
                     state_d = StChars;
                     idx_d   = 5'd0;
                  end
                  StLine2Addr: begin
                     state_d = StChars;
                     idx_d   = 5'd16;
                  end
                  StChars: begin
                     if (idx_q == 5'd15) begin
                        state_d = StLine2Addr;
                     end else if (idx_q == 5'd31) begin
                        frame_done_d = 1'b1;
                        state_d      = StLine1Addr;
                     end else begin
                        idx_d = idx_q + 5'd1;
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end

      // On SETUP entry, latch the byte for the new transaction. It stays on the bus
      // until the next transaction starts.
      if (start) begin
         cnt_d   = '0;
         phase_d = PhSetup;
         case (state_d)
            StInit:      begin rs_d = 1'b0; db_d = init_cmd(idx_d[2:0]); end
            StLine1Addr: begin rs_d = 1'b0; db_d = 8'h80; end
            StLine2Addr: begin rs_d = 1'b0; db_d = 8'hC0; end
            StChars:     begin rs_d = 1'b1; db_d = char_q[idx_d]; end
            default: ;
         endcase
      end
   end

   always_comb begin
      lcd_e      = (state_q != StPwrupWait) && (phase_q == PhEhigh);
      lcd_rs     = rs_q;
      lcd_rw     = 1'b0;
      lcd_db     = db_q;
      init_done  = init_done_q;
      frame_done = frame_done_q;
   end

endmodule

// File: tb/tb_lcd_hd44780_refresh.sv
// Bench for lcd_hd44780_refresh. It uses short timing parameters. A monitor
// records every E pulse, every frame_done pulse and the init_done rise. A model
// predicts each transaction. The model has two parts: the command/character
// schedule, and a log of writes that gives the buffer content at any latch
// edge.
`timescale 1ns/1ps
module tb_lcd_hd44780_refresh;
   localparam int TPwr = 100, TAs = 2, TPw = 4, TCmd = 10, TClr = 40;
   localparam int TTxn = TAs + TPw + TCmd;
   localparam int TFrame = 34;

   logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [4:0] wr_addr = 5'd0;
   logic lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
   logic [7:0] lcd_db;

   lcd_hd44780_refresh #(
      .T_POWERUP(TPwr), .T_AS(TAs), .T_PW(TPw), .T_CMD(TCmd), .T_CLEAR(TClr)
   ) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
      .init_done(init_done), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {logic rs; logic [7:0] db; int rise; int width; bit unstable;} pulse_t;
   typedef struct {int cyc; logic [4:0] addr; logic [7:0] data;} wr_t;

   int cyc;
   int checks = 0, errors = 0, rst_cyc = 0, id_rise = -1, rw_bad = 0;
   pulse_t pulse_q[$];
   pulse_t cur;
   int fd_q[$];
   wr_t wlog[$];
   logic e_prev = 1'b0, id_prev = 1'b0;
   logic [7:0] init_rom [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
         cur.rs = lcd_rs; cur.db = lcd_db; cur.rise = cyc; cur.unstable = 1'b0;
      end else if (lcd_e === 1'b1 && (lcd_rs !== cur.rs || lcd_db !== cur.db)) begin
         cur.unstable = 1'b1;
      end
      if (lcd_e !== 1'b1 && e_prev === 1'b1) begin
         cur.width = cyc - cur.rise;
         pulse_q.push_back(cur);
      end
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      if (init_done === 1'b1 && id_prev !== 1'b1) id_rise = cyc;
      if (lcd_rw !== 1'b0) rw_bad++;
      e_prev = lcd_e;
      id_prev = init_done;
   end

   // Edge at which transaction n (counted from reset) enters SETUP.
   function automatic int setup_edge(input int n);
      return rst_cyc + TPwr + n * TTxn + ((n > 5) ? (TClr - TCmd) : 0);
   endfunction

   // Buffer content at position p as seen by a latch on edge e.
   function automatic logic [7:0] model_char(input int p, input int e);
      logic [7:0] v = 8'h20;
      foreach (wlog[i]) if (wlog[i].cyc < e && int'(wlog[i].addr) == p) v = wlog[i].data;
      return v;
   endfunction

   // Expected {rs, db} for transaction n.
   function automatic logic [8:0] exp_txn(input int n);
      int k;
      if (n < 8) return {1'b0, init_rom[n]};
      k = (n - 8) % TFrame;
      if (k == 0) return {1'b0, 8'h80};
      if (k == 17) return {1'b0, 8'hC0};
      return {1'b1, model_char((k < 17) ? k - 1 : k - 2, setup_edge(n))};
   endfunction

   function automatic string pstr(input int n);
      return $sformatf("got rs=%0b db=%02h rise=%0d width=%0d unstable=%0b", pulse_q[n].rs,
                       pulse_q[n].db, pulse_q[n].rise, pulse_q[n].width, pulse_q[n].unstable);
   endfunction

   function automatic string estr(input int n);
      logic [8:0] x = exp_txn(n);
      return $sformatf("expected rs=%0b db=%02h rise=%0d width=%0d", x[8], x[7:0],
                       setup_edge(n) + TAs, TPw);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wr_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rst_cyc = cyc;
      pulse_q.delete(); fd_q.delete(); wlog.delete(); id_rise = -1;
   endtask

   task automatic wait_pulses(input int n, output bit ok);
      int b = 0;
      while (pulse_q.size() < n && b < 20000) begin @(negedge clk); b++; end
      ok = (pulse_q.size() >= n);
   endtask

   task automatic write_now(input logic [4:0] a, input logic [7:0] d);
      wr_addr = a; wr_data = d; wr_en = 1'b1;
      wlog.push_back(wr_t'{cyc + 1, a, d});
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (lcd_e !== 1'b0) begin errors++; $display("FAIL reset_e: got %b expected 0", lcd_e); end
      checks++;
      if ({lcd_rs, lcd_rw, lcd_db} !== 10'h000) begin
         errors++; $display("FAIL reset_bus: got rs=%b rw=%b db=%h expected 0/0/00",
                            lcd_rs, lcd_rw, lcd_db);
      end
      checks++;
      if ({init_done, frame_done} !== 2'b00) begin
         errors++; $display("FAIL reset_flags: got init_done=%b frame_done=%b expected 0/0",
                            init_done, frame_done);
      end
   endtask

   task automatic test_init();
      bit ok;
      wait_pulses(9, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL init_timeout: got %0d pulses expected 9", pulse_q.size());
         return;
      end
      for (int n = 0; n < 8; n++) begin
         checks++;
         if ({pulse_q[n].rs, pulse_q[n].db} !== exp_txn(n) || pulse_q[n].rise != setup_edge(n) + TAs
             || pulse_q[n].width != TPw || pulse_q[n].unstable) begin
            errors++; $display("FAIL init_pulse[%0d]: %s %s", n, pstr(n), estr(n));
         end
      end
      checks++;
      if (pulse_q[6].rise - TAs - (pulse_q[5].rise + TPw) != TClr) begin
         errors++; $display("FAIL clear_wait: got %0d expected %0d",
                            pulse_q[6].rise - TAs - (pulse_q[5].rise + TPw), TClr);
      end
      checks++;
      if (id_rise != setup_edge(8)) begin
         errors++; $display("FAIL init_done_rise: got %0d expected %0d", id_rise, setup_edge(8));
      end
   endtask

   task automatic test_default_frame();
      bit ok;
      wait_pulses(8 + 2 * TFrame + 1, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL frame_timeout: got %0d pulses", pulse_q.size());
         return;
      end
      for (int n = 8; n < 8 + TFrame; n++) begin
         checks++;
         if ({pulse_q[n].rs, pulse_q[n].db} !== exp_txn(n) || pulse_q[n].rise != setup_edge(n) + TAs
             || pulse_q[n].width != TPw || pulse_q[n].unstable) begin
            errors++; $display("FAIL default_pulse[%0d]: %s %s", n, pstr(n), estr(n));
         end
      end
      checks++;
      if (fd_q.size() != 2) begin
         errors++; $display("FAIL frame_done_count: got %0d expected 2", fd_q.size());
      end else begin
         checks++;
         if (fd_q[0] != setup_edge(8 + TFrame)) begin
            errors++; $display("FAIL frame_done_time: got %0d expected %0d", fd_q[0],
                               setup_edge(8 + TFrame));
         end
         checks++;
         if (fd_q[1] - fd_q[0] != TFrame * TTxn) begin
            errors++; $display("FAIL frame_period: got %0d expected %0d", fd_q[1] - fd_q[0],
                               TFrame * TTxn);
         end
      end
   endtask

   task automatic test_collision();
      int f = 0, t, b = 0;
      bit ok;
      do begin t = 8 + TFrame * f + 6; f++; end while (setup_edge(t) - 1 <= cyc + 1);
      while (cyc < setup_edge(t) - 1 && b < 20000) begin @(negedge clk); b++; end
      write_now(5'd5, 8'h41);
      wait_pulses(t + TFrame + 1, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL collision_timeout: got %0d pulses", pulse_q.size());
         return;
      end
      checks++;
      if ({pulse_q[t].rs, pulse_q[t].db} !== 9'h120 || exp_txn(t) !== 9'h120) begin
         errors++; $display("FAIL collision_old: %s expected rs=1 db=20", pstr(t));
      end
      checks++;
      if ({pulse_q[t + TFrame].rs, pulse_q[t + TFrame].db} !== 9'h141) begin
         errors++; $display("FAIL collision_new: %s expected rs=1 db=41", pstr(t + TFrame));
      end
   endtask

   task automatic test_mid_reset();
      int b = 0;
      bit ok;
      while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && b < 5000) begin @(negedge clk); b++; end
      checks++;
      if (b >= 5000) begin errors++; $display("FAIL midreset_no_char: got none expected E"); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (lcd_e !== 1'b0 || init_done !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs: got e=%b init_done=%b expected 0/0",
                            lcd_e, init_done);
      end
      rst = 1'b0;
      rst_cyc = cyc;
      pulse_q.delete(); fd_q.delete(); wlog.delete(); id_rise = -1;
      wait_pulses(8 + 18, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL midreset_timeout: got %0d pulses", pulse_q.size());
         return;
      end
      for (int n = 0; n < 8 + 18; n++) begin
         checks++;
         if ({pulse_q[n].rs, pulse_q[n].db} !== exp_txn(n) || pulse_q[n].rise != setup_edge(n) + TAs
             || pulse_q[n].width != TPw || pulse_q[n].unstable) begin
            errors++; $display("FAIL midreset_pulse[%0d]: %s %s", n, pstr(n), estr(n));
         end
      end
      for (int n = 9; n < 25; n++) begin
         checks++;
         if (pulse_q[n].db !== 8'h20) begin
            errors++; $display("FAIL midreset_blank[%0d]: got %02h expected 20", n, pulse_q[n].db);
         end
      end
   endtask

   task automatic test_write_during_init();
      bit ok;
      logic [7:0] want;
      do_reset();
      write_now(5'd0, 8'h58);
      write_now(5'd1, 8'h3A);
      write_now(5'd16, 8'h31);
      wait_pulses(8 + TFrame, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL wrinit_timeout: got %0d pulses", pulse_q.size());
         return;
      end
      for (int n = 8; n < 8 + TFrame; n++) begin
         checks++;
         if ({pulse_q[n].rs, pulse_q[n].db} !== exp_txn(n) || pulse_q[n].rise != setup_edge(n) + TAs
             || pulse_q[n].width != TPw || pulse_q[n].unstable) begin
            errors++; $display("FAIL wrinit_pulse[%0d]: %s %s", n, pstr(n), estr(n));
         end
      end
      for (int n = 9; n < 27; n++) begin
         want = (n == 9) ? 8'h58 : (n == 10) ? 8'h3A : (n == 26) ? 8'h31 :
                (n == 25) ? 8'hC0 : 8'h20;
         checks++;
         if (pulse_q[n].db !== want) begin
            errors++; $display("FAIL wrinit_char[%0d]: got %02h expected %02h", n,
                               pulse_q[n].db, want);
         end
      end
   endtask

   task automatic test_continuous();
      int f0 = 0, first, last, end_edge;
      bit ok;
      while (setup_edge(8 + TFrame * f0) <= cyc + 1) f0++;
      first = 8 + TFrame * f0;
      last = first + 3 * TFrame;
      end_edge = setup_edge(last);
      while (cyc < end_edge) begin
         wr_addr = 5'($urandom_range(31));
         wr_data = 8'($urandom);
         wr_en = 1'b1;
         wlog.push_back(wr_t'{cyc + 1, wr_addr, wr_data});
         @(negedge clk);
      end
      wr_en = 1'b0;
      wait_pulses(last, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL cont_timeout: got %0d pulses", pulse_q.size());
         return;
      end
      for (int n = first; n < last; n++) begin
         checks++;
         if ({pulse_q[n].rs, pulse_q[n].db} !== exp_txn(n) || pulse_q[n].rise != setup_edge(n) + TAs
             || pulse_q[n].width != TPw || pulse_q[n].unstable) begin
            errors++; $display("FAIL cont_pulse[%0d]: %s %s", n, pstr(n), estr(n));
         end
      end
      foreach (fd_q[i]) begin
         checks++;
         if (fd_q[i] != setup_edge(8 + TFrame * (i + 1))) begin
            errors++; $display("FAIL cont_frame_done[%0d]: got %0d expected %0d", i, fd_q[i],
                               setup_edge(8 + TFrame * (i + 1)));
         end
      end
      checks++;
      if (rw_bad != 0) begin errors++; $display("FAIL rw_low: got %0d high cycles expected 0", rw_bad); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_default_frame();
      test_collision();
      test_mid_reset();
      test_write_during_init();
      test_continuous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
